fpu_dispatcher: RTL and testbench

- Request-side controller for the fixed-point unit.
- Accepts fixed-point operations from the core over a valid/ready request channel.
- Drives the fixed-point unit's operand/operation inputs, holds them stable until the unit raises `ready`, and captures the result.
- Returns the result on a valid/ready response channel.
- Inserts the idle gap the unit's multi-cycle sequencers need between back-to-back operations.

---
 rtl/fpu_dispatcher_pkg.sv | 26 ++
 rtl/fpu_dispatcher_watchdog.sv | 30 +++
 rtl/fpu_dispatcher.sv | 128 ++++++++++++
 tb/tb_fpu_dispatcher.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpu_dispatcher_pkg.sv
// rtl/fpu_dispatcher_pkg.sv - op codes, FSM state encodings and helpers shared by the FPU dispatcher
package fpu_dispatcher_pkg;

  // Operation codes understood by the fixed-point unit
  localparam logic [1:0] FPU_ADD  = 2'd0;
  localparam logic [1:0] FPU_SUB  = 2'd1;
  localparam logic [1:0] FPU_MUL  = 2'd2;
  localparam logic [1:0] FPU_SQRT = 2'd3;

  // Code driven whenever no operation is being issued; it is not MUL/SQRT,
  // so the unit's multi-cycle sequencers reset during it
  localparam logic [1:0] FPU_DISP_IDLE_OP = FPU_ADD;

  typedef enum logic [1:0] {
    FPU_DISP_IDLE  = 2'd0,
    FPU_DISP_ISSUE = 2'd1,
    FPU_DISP_WAIT  = 2'd2,
    FPU_DISP_RESP  = 2'd3
  } fpu_disp_state_e;

  // ADD and SUB complete combinationally in the unit within the issue cycle
  function automatic logic is_single_cycle(input logic [1:0] op);
    return (op == FPU_ADD) || (op == FPU_SUB);
  endfunction

endpackage

// File: rtl/fpu_dispatcher_watchdog.sv
// rtl/fpu_dispatcher_watchdog.sv - WAIT-state cycle counter with limit compare (used under FPU_DISPATCH_TIMEOUT_EN)
module fpu_dispatch_watchdog #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic count_en,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] count;

  // Count WAIT cycles; cleared in the cycle before WAIT is entered
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (count_en) begin
      count <= count + 1'b1;
    end
  end

  // Fires in the TIMEOUT_CYCLES-th WAIT cycle
  assign expired = count_en && (count == CW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/fpu_dispatcher.sv
// rtl/fpu_dispatcher.sv - request/response controller for the fixed-point unit; optional watchdog via FPU_DISPATCH_TIMEOUT_EN
module fpu_dispatcher
  import fpu_dispatcher_pkg::*;
#(
  parameter int WIDTH          = 32,
  parameter int FBITS          = 10,
  parameter int TAG_W          = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_op,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  input  logic [TAG_W-1:0] req_tag,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [WIDTH-1:0] resp_result,
  output logic [TAG_W-1:0] resp_tag,
  output logic             resp_error,
  output logic [WIDTH-1:0] fpu_operand_1,
  output logic [WIDTH-1:0] fpu_operand_2,
  output logic [1:0]       fpu_operation,
  input  logic [WIDTH-1:0] fpu_result,
  input  logic             fpu_ready,
  output logic             busy
);

  // Elaboration-time sanity checks on the configuration
  if (FBITS >= WIDTH) begin : g_fbits_check
    $error("FBITS must be smaller than WIDTH");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_timeout_check
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  fpu_disp_state_e  state;
  logic [TAG_W-1:0] tag_q;
  logic             timeout_hit;

`ifdef FPU_DISPATCH_TIMEOUT_EN
  fpu_dispatch_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk      (clk),
    .reset    (reset),
    .clear    (state == FPU_DISP_ISSUE),
    .count_en (state == FPU_DISP_WAIT),
    .expired  (timeout_hit)
  );
`else
  assign timeout_hit = 1'b0;
`endif

  // Handshake flags are decoded from state; req_ready is also held low during reset
  assign req_ready  = reset && (state == FPU_DISP_IDLE);
  assign resp_valid = (state == FPU_DISP_RESP);
  assign busy       = (state != FPU_DISP_IDLE);

  // Dispatch FSM; the unit-facing operand/op registers double as the request latch
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= FPU_DISP_IDLE;
      tag_q         <= '0;
      fpu_operation <= FPU_DISP_IDLE_OP;
      fpu_operand_1 <= '0;
      fpu_operand_2 <= '0;
      resp_result   <= '0;
      resp_tag      <= '0;
      resp_error    <= 1'b0;
    end else begin
      case (state)
        FPU_DISP_IDLE: begin
          if (req_valid) begin
            fpu_operation <= req_op;
            fpu_operand_1 <= req_a;
            fpu_operand_2 <= req_b;
            tag_q         <= req_tag;
            state         <= FPU_DISP_ISSUE;
          end
        end
        FPU_DISP_ISSUE: begin
          // Any fpu_ready seen here for MUL/SQRT is left over from a previous op
          if (is_single_cycle(fpu_operation)) begin
            resp_result   <= fpu_result;
            resp_tag      <= tag_q;
            resp_error    <= 1'b0;
            fpu_operation <= FPU_DISP_IDLE_OP;
            fpu_operand_1 <= '0;
            fpu_operand_2 <= '0;
            state         <= FPU_DISP_RESP;
          end else begin
            state <= FPU_DISP_WAIT;
          end
        end
        FPU_DISP_WAIT: begin
          // A ready arriving with the limit still counts as normal completion
          if (fpu_ready) begin
            resp_result   <= fpu_result;
            resp_tag      <= tag_q;
            resp_error    <= 1'b0;
            fpu_operation <= FPU_DISP_IDLE_OP;
            fpu_operand_1 <= '0;
            fpu_operand_2 <= '0;
            state         <= FPU_DISP_RESP;
          end else if (timeout_hit) begin
            resp_result   <= '0;
            resp_tag      <= tag_q;
            resp_error    <= 1'b1;
            fpu_operation <= FPU_DISP_IDLE_OP;
            fpu_operand_1 <= '0;
            fpu_operand_2 <= '0;
            state         <= FPU_DISP_RESP;
          end
        end
        FPU_DISP_RESP: begin
          if (resp_ready) begin
            state <= FPU_DISP_IDLE;
          end
        end
        default: state <= FPU_DISP_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fpu_dispatcher.sv
// tb/tb_fpu_dispatcher.sv - directed self-checking bench for fpu_dispatcher with a behavioural fixed-point unit
module tb_fpu_dispatcher;
  import fpu_dispatcher_pkg::*;

  localparam int WIDTH = 32;
  localparam int TAG_W = 4;
  localparam int TMO   = 64;

  logic             clk;
  logic             reset;
  logic             req_valid;
  logic             req_ready;
  logic [1:0]       req_op;
  logic [WIDTH-1:0] req_a;
  logic [WIDTH-1:0] req_b;
  logic [TAG_W-1:0] req_tag;
  logic             resp_valid;
  logic             resp_ready;
  logic [WIDTH-1:0] resp_result;
  logic [TAG_W-1:0] resp_tag;
  logic             resp_error;
  logic [WIDTH-1:0] fpu_operand_1;
  logic [WIDTH-1:0] fpu_operand_2;
  logic [1:0]       fpu_operation;
  logic [WIDTH-1:0] fpu_result;
  logic             fpu_ready;
  logic             busy;

  int total = 0;
  int bad   = 0;

  fpu_dispatcher #(
    .WIDTH(WIDTH), .FBITS(10), .TAG_W(TAG_W), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b), .req_tag(req_tag),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_result(resp_result),
    .resp_tag(resp_tag), .resp_error(resp_error),
    .fpu_operand_1(fpu_operand_1), .fpu_operand_2(fpu_operand_2),
    .fpu_operation(fpu_operation), .fpu_result(fpu_result), .fpu_ready(fpu_ready),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural Q.10 unit: result follows its inputs, ready is bench-driven
  function automatic logic [31:0] isqrt(input logic [63:0] v);
    logic [31:0] r;
    logic [31:0] t;
    r = '0;
    for (int b = 31; b >= 0; b--) begin
      t = r | (32'd1 << b);
      if ({32'd0, t} * {32'd0, t} <= v) r = t;
    end
    return r;
  endfunction

  logic signed [63:0] mul_full;
  assign mul_full = $signed({{32{fpu_operand_1[31]}}, fpu_operand_1}) *
                    $signed({{32{fpu_operand_2[31]}}, fpu_operand_2});

  always_comb begin
    fpu_result = '0;
    case (fpu_operation)
      FPU_ADD:  fpu_result = fpu_operand_1 + fpu_operand_2;
      FPU_SUB:  fpu_result = fpu_operand_1 - fpu_operand_2;
      FPU_MUL:  fpu_result = mul_full[41:10];
      FPU_SQRT: fpu_result = isqrt({22'd0, fpu_operand_1, 10'd0});
      default:  fpu_result = '0;
    endcase
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a request and return one step after the accepting edge (DUT then in ISSUE)
  task automatic send(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic [3:0] tag);
    int n;
    n = 0;
    req_op = op; req_a = a; req_b = b; req_tag = tag; req_valid = 1'b1;
    while (!req_ready && n < 50) begin
      step();
      n++;
    end
    if (!req_ready) check("send_ready", {63'd0, req_ready}, 64'd1);
    else step();
    req_valid = 1'b0;
  endtask

  task automatic wait_resp(input int max, output int cycles);
    cycles = 0;
    while (!resp_valid && cycles < max) begin
      step();
      cycles++;
    end
    check("resp_arrives", {63'd0, resp_valid}, 64'd1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (busy && n < 200) begin
      step();
      n++;
    end
    check("drain_idle", {63'd0, busy}, 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout");
    $fatal(1, "simulation did not finish");
  end

  initial begin
    int c;
    int acc;
    reset = 1'b0; req_valid = 1'b0; req_op = FPU_ADD; req_a = '0; req_b = '0;
    req_tag = '0; resp_ready = 1'b1; fpu_ready = 1'b0;

    // Reset values
    #12;
    check("rst_req_ready", {63'd0, req_ready}, 64'd0);
    check("rst_resp_valid", {63'd0, resp_valid}, 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_op", {62'd0, fpu_operation}, 64'(FPU_ADD));
    check("rst_opnd1", {32'd0, fpu_operand_1}, 64'd0);
    check("rst_result", {32'd0, resp_result}, 64'd0);
    @(negedge clk);
    reset = 1'b1;
    step();
    check("post_rst_req_ready", {63'd0, req_ready}, 64'd1);

    // ADD 1.5 + 2.25
    send(FPU_ADD, 32'h600, 32'h900, 4'd3);
    check("add_issue_busy", {63'd0, busy}, 64'd1);
    check("add_issue_req_ready", {63'd0, req_ready}, 64'd0);
    check("add_issue_valid", {63'd0, resp_valid}, 64'd0);
    check("add_issue_op", {62'd0, fpu_operation}, 64'(FPU_ADD));
    check("add_issue_a", {32'd0, fpu_operand_1}, 64'h600);
    check("add_issue_b", {32'd0, fpu_operand_2}, 64'h900);
    step();
    check("add_valid", {63'd0, resp_valid}, 64'd1);
    check("add_result", {32'd0, resp_result}, 64'hF00);
    check("add_tag", {60'd0, resp_tag}, 64'd3);
    check("add_error", {63'd0, resp_error}, 64'd0);
    check("add_resp_opnd1", {32'd0, fpu_operand_1}, 64'd0);
    step();
    check("add_done_valid", {63'd0, resp_valid}, 64'd0);
    check("add_done_req_ready", {63'd0, req_ready}, 64'd1);

    // SUB with negative result
    send(FPU_SUB, 32'h400, 32'h800, 4'd4);
    wait_resp(5, c);
    check("sub_latency", 64'(c), 64'd1);
    check("sub_result", {32'd0, resp_result}, 64'hFFFF_FC00);
    check("sub_tag", {60'd0, resp_tag}, 64'd4);
    step();

    // Back-to-back ADDs: one accept every 3 cycles
    req_op = FPU_ADD; req_a = 32'h400; req_b = 32'h400; req_tag = 4'd1; req_valid = 1'b1;
    acc = 0;
    for (int i = 0; i < 9; i++) begin
      if (req_ready) acc++;
      step();
    end
    req_valid = 1'b0;
    check("b2b_accepts", 64'(acc), 64'd3);
    drain();

    // MUL with fpu_ready stuck high: ISSUE must ignore it
    fpu_ready = 1'b1;
    send(FPU_MUL, 32'hC00, 32'h800, 4'd5);
    check("mul1_issue_op", {62'd0, fpu_operation}, 64'(FPU_MUL));
    step();
    check("mul1_stale_guard", {63'd0, resp_valid}, 64'd0);
    check("mul1_wait_op", {62'd0, fpu_operation}, 64'(FPU_MUL));
    check("mul1_wait_a", {32'd0, fpu_operand_1}, 64'hC00);
    step();
    check("mul1_valid", {63'd0, resp_valid}, 64'd1);
    check("mul1_result", {32'd0, resp_result}, 64'h1800);
    check("mul1_tag", {60'd0, resp_tag}, 64'd5);
    check("mul_gap_op", {62'd0, fpu_operation}, 64'(FPU_ADD));
    step();
    check("mul_gap_idle_op", {62'd0, fpu_operation}, 64'(FPU_ADD));
    send(FPU_MUL, 32'h400, 32'h400, 4'd6);
    wait_resp(10, c);
    check("mul2_latency", 64'(c), 64'd2);
    check("mul2_result", {32'd0, resp_result}, 64'h400);
    step();
    fpu_ready = 1'b0;

    // SQRT 4.0 with a late ready
    send(FPU_SQRT, 32'h1000, 32'hDEAD, 4'd8);
    for (int i = 0; i < 3; i++) begin
      step();
      check("sqrt_waiting", {63'd0, resp_valid}, 64'd0);
      check("sqrt_hold_op", {62'd0, fpu_operation}, 64'(FPU_SQRT));
    end
    fpu_ready = 1'b1;
    step();
    fpu_ready = 1'b0;
    check("sqrt_valid", {63'd0, resp_valid}, 64'd1);
    check("sqrt_result", {32'd0, resp_result}, 64'h800);
    step();

    // Backpressure with a pending follow-up request
    resp_ready = 1'b0;
    send(FPU_ADD, 32'h100, 32'h200, 4'd9);
    step();
    req_op = FPU_ADD; req_a = 32'h10; req_b = 32'h20; req_tag = 4'hA; req_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", {63'd0, resp_valid}, 64'd1);
      check("bp_result", {32'd0, resp_result}, 64'h300);
      check("bp_tag", {60'd0, resp_tag}, 64'd9);
      check("bp_req_ready", {63'd0, req_ready}, 64'd0);
      step();
    end
    resp_ready = 1'b1;
    step();
    check("bp_after_hs_busy", {63'd0, busy}, 64'd0);
    check("bp_after_hs_valid", {63'd0, resp_valid}, 64'd0);
    check("bp_after_hs_req_ready", {63'd0, req_ready}, 64'd1);
    step();
    req_valid = 1'b0;
    check("bp_next_accepted", {63'd0, busy}, 64'd1);
    check("bp_next_a", {32'd0, fpu_operand_1}, 64'h10);
    wait_resp(5, c);
    check("bp_next_result", {32'd0, resp_result}, 64'h30);
    check("bp_next_tag", {60'd0, resp_tag}, 64'hA);
    step();

    // Reset in the middle of a MUL wait
    send(FPU_MUL, 32'h800, 32'h800, 4'd7);
    step();
    step();
    #2;
    reset = 1'b0;
    #1;
    check("mid_rst_busy", {63'd0, busy}, 64'd0);
    check("mid_rst_valid", {63'd0, resp_valid}, 64'd0);
    check("mid_rst_req_ready", {63'd0, req_ready}, 64'd0);
    check("mid_rst_op", {62'd0, fpu_operation}, 64'(FPU_ADD));
    check("mid_rst_opnd1", {32'd0, fpu_operand_1}, 64'd0);
    check("mid_rst_opnd2", {32'd0, fpu_operand_2}, 64'd0);
    check("mid_rst_result", {32'd0, resp_result}, 64'd0);
    check("mid_rst_tag", {60'd0, resp_tag}, 64'd0);
    @(negedge clk);
    reset = 1'b1;
    fpu_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      check("dropped_no_resp", {63'd0, resp_valid}, 64'd0);
    end
    fpu_ready = 1'b0;
    send(FPU_ADD, 32'h400, 32'h400, 4'd2);
    wait_resp(5, c);
    check("post_rst_add", {32'd0, resp_result}, 64'h800);
    step();

`ifdef FPU_DISPATCH_TIMEOUT_EN
    // Watchdog expiry with fpu_ready stuck low
    send(FPU_MUL, 32'h400, 32'h400, 4'd2);
    wait_resp(TMO + 10, c);
    check("tmo_latency", 64'(c), 64'(TMO + 1));
    check("tmo_error", {63'd0, resp_error}, 64'd1);
    check("tmo_result", {32'd0, resp_result}, 64'd0);
    step();
    // Ready on the limit cycle wins
    send(FPU_MUL, 32'h400, 32'h400, 4'd3);
    for (int i = 0; i < TMO; i++) step();
    check("tmo_edge_pending", {63'd0, resp_valid}, 64'd0);
    fpu_ready = 1'b1;
    step();
    fpu_ready = 1'b0;
    check("tmo_edge_valid", {63'd0, resp_valid}, 64'd1);
    check("tmo_edge_error", {63'd0, resp_error}, 64'd0);
    check("tmo_edge_result", {32'd0, resp_result}, 64'h400);
    step();
`else
    check("no_tmo_error", {63'd0, resp_error}, 64'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
